game_engine: RTL and testbench

Per-frame game-state sequencer that owns every object position consumed by the pixel colour controller. On each frame tick it moves the plane from button input, scrolls the mountains and drops the lava, runs bounding-box collision checks and manages lives and game over. It sits between the VGA timing generator, which supplies the frame tick, and the colour controller, which reads all outputs. Outputs change only in the few cycles after a frame tick, so they are stable during active video.

---
 rtl/game_engine_if.sv | 31 +++
 rtl/game_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_game_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/game_engine_if.sv
// rtl/game_engine_if.sv - frame controls in, object positions and game status out
interface game_engine_if;
  logic        frame_tick;
  logic        start;
  logic        btn_up;
  logic        btn_down;
  logic [9:0]  plane_y;
  logic [9:0]  mountain1_x;
  logic [9:0]  mountain1_y;
  logic [9:0]  mountain2_x;
  logic [9:0]  mountain2_y;
  logic [9:0]  lava_x;
  logic [9:0]  lava_y;
  logic [9:0]  life;
  logic        game_over;
  logic [15:0] score;

  // Bench / timing-generator side: drives controls, observes game state
  modport master (
    output frame_tick, start, btn_up, btn_down,
    input  plane_y, mountain1_x, mountain1_y, mountain2_x, mountain2_y,
    input  lava_x, lava_y, life, game_over, score
  );

  // Engine side
  modport slave (
    input  frame_tick, start, btn_up, btn_down,
    output plane_y, mountain1_x, mountain1_y, mountain2_x, mountain2_y,
    output lava_x, lava_y, life, game_over, score
  );
endinterface

// File: rtl/game_engine.sv
// rtl/game_engine.sv - per-frame game-state sequencer (move, collide, lives, game over)
module game_engine #(
  parameter int PLANE_X     = 100,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PLANE_STEP  = 4,
  parameter int SCROLL_STEP = 2,
  parameter int LAVA_STEP   = 3,
  parameter int HIT_FRAMES  = 60
) (
  input logic          clk,
  input logic          resetn,
  game_engine_if.slave bus
);

  localparam int CW = $clog2(HIT_FRAMES + 1);

  // Object extents: plane and lava are 17 px squares, mountains 31 px wide
  localparam logic [10:0] OBJ_EXT = 11'd16;
  localparam logic [10:0] MTN_EXT = 11'd30;

  localparam logic [9:0]  PLANE_Y_INIT = 10'd232;
  localparam logic [9:0]  M1_X_INIT    = 10'd640;
  localparam logic [9:0]  M1_Y_INIT    = 10'd380;
  localparam logic [9:0]  M2_X_INIT    = 10'd960;
  localparam logic [9:0]  M2_Y_INIT    = 10'd340;
  localparam logic [9:0]  LAVA_X_INIT  = 10'd400;
  localparam logic [9:0]  LAVA_Y_INIT  = 10'd0;
  localparam logic [9:0]  LIFE_INIT    = 10'd3;
  localparam logic [15:0] LFSR_INIT    = 16'hACE1;
  localparam logic [9:0]  MTN_Y_BASE   = 10'd300;
  localparam logic [9:0]  LAVA_X_BASE  = 10'd200;

  localparam logic [10:0] PX        = 11'(PLANE_X);
  localparam logic [10:0] PLANE_MAX = 11'(SCREEN_H - 17);
  localparam logic [10:0] P_STEP    = 11'(PLANE_STEP);
  localparam logic [9:0]  S_STEP    = 10'(SCROLL_STEP);
  localparam logic [10:0] L_STEP    = 11'(LAVA_STEP);
  localparam logic [10:0] SCR_H     = 11'(SCREEN_H);
  localparam logic [9:0]  SCR_W     = 10'(SCREEN_W);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HIT, S_OVER} state_t;
  typedef enum logic [1:0] {PH_WAIT, PH_MOVE, PH_CHECK, PH_COMMIT} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [9:0]    plane_y_q, plane_y_d;
  logic [9:0]    m1_x_q, m1_x_d, m1_y_q, m1_y_d;
  logic [9:0]    m2_x_q, m2_x_d, m2_y_q, m2_y_d;
  logic [9:0]    lava_x_q, lava_x_d, lava_y_q, lava_y_d;
  logic [9:0]    life_q, life_d;
  logic          game_over_q, game_over_d;
  logic [15:0]   score_q, score_d;
  logic          hit_q, hit_d;
  logic [CW-1:0] cool_q, cool_d;

  logic [10:0] py;
  logic [10:0] plane_dn_sum;
  logic [10:0] lava_sum;
  logic        lfsr_fb;
  logic        overlap;

  // Inclusive box overlap between the plane and a mountain reaching the screen bottom
  function automatic logic mtn_overlap(input logic [10:0] pyv, input logic [9:0] mx,
                                       input logic [9:0] my);
    logic [10:0] x;
    logic [10:0] y;
    x = {1'b0, mx};
    y = {1'b0, my};
    return (PX <= x + MTN_EXT) && (x <= PX + OBJ_EXT) && (pyv + OBJ_EXT >= y);
  endfunction

  // Inclusive box overlap between the plane and the lava block
  function automatic logic lava_overlap(input logic [10:0] pyv, input logic [9:0] lx,
                                        input logic [9:0] ly);
    logic [10:0] x;
    logic [10:0] y;
    x = {1'b0, lx};
    y = {1'b0, ly};
    return (PX <= x + OBJ_EXT) && (x <= PX + OBJ_EXT) &&
           (pyv <= y + OBJ_EXT) && (y <= pyv + OBJ_EXT);
  endfunction

  assign py           = {1'b0, plane_y_q};
  assign plane_dn_sum = py + P_STEP;
  assign lava_sum     = {1'b0, lava_y_q} + L_STEP;
  assign lfsr_fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign overlap      = mtn_overlap(py, m1_x_q, m1_y_q) ||
                        mtn_overlap(py, m2_x_q, m2_y_q) ||
                        lava_overlap(py, lava_x_q, lava_y_q);

  // Next-state logic: start handling, frame phases and play/hit/over transitions
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_fb};
    plane_y_d   = plane_y_q;
    m1_x_d      = m1_x_q;
    m1_y_d      = m1_y_q;
    m2_x_d      = m2_x_q;
    m2_y_d      = m2_y_q;
    lava_x_d    = lava_x_q;
    lava_y_d    = lava_y_q;
    life_d      = life_q;
    game_over_d = game_over_q;
    score_d     = score_q;
    hit_d       = hit_q;
    cool_d      = cool_q;

    if ((state_q == S_IDLE || state_q == S_OVER) && bus.start) begin
      // Fresh game: every visible object back to its starting place
      state_d     = S_PLAY;
      phase_d     = PH_WAIT;
      plane_y_d   = PLANE_Y_INIT;
      m1_x_d      = M1_X_INIT;
      m1_y_d      = M1_Y_INIT;
      m2_x_d      = M2_X_INIT;
      m2_y_d      = M2_Y_INIT;
      lava_x_d    = LAVA_X_INIT;
      lava_y_d    = LAVA_Y_INIT;
      life_d      = LIFE_INIT;
      game_over_d = 1'b0;
      score_d     = 16'd0;
      hit_d       = 1'b0;
      cool_d      = '0;
    end else if (state_q == S_PLAY || state_q == S_HIT) begin
      case (phase_q)
        PH_WAIT: begin
          if (bus.frame_tick) phase_d = PH_MOVE;
        end
        PH_MOVE: begin
          if (bus.btn_up && !bus.btn_down) begin
            plane_y_d = (py < P_STEP) ? 10'd0 : plane_y_q - P_STEP[9:0];
          end else if (bus.btn_down && !bus.btn_up) begin
            plane_y_d = (plane_dn_sum > PLANE_MAX) ? PLANE_MAX[9:0] : plane_dn_sum[9:0];
          end
          if (m1_x_q < S_STEP) begin
            m1_x_d = SCR_W;
            m1_y_d = MTN_Y_BASE + {3'b000, lfsr_q[6:0]};
          end else begin
            m1_x_d = m1_x_q - S_STEP;
          end
          if (m2_x_q < S_STEP) begin
            m2_x_d = SCR_W;
            m2_y_d = MTN_Y_BASE + {3'b000, lfsr_q[14:8]};
          end else begin
            m2_x_d = m2_x_q - S_STEP;
          end
          if (lava_sum >= SCR_H) begin
            lava_y_d = 10'd0;
            lava_x_d = LAVA_X_BASE + {2'b00, lfsr_q[7:0]};
          end else begin
            lava_y_d = lava_sum[9:0];
          end
          phase_d = PH_CHECK;
        end
        PH_CHECK: begin
          hit_d   = overlap;
          phase_d = PH_COMMIT;
        end
        PH_COMMIT: begin
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          if (state_q == S_PLAY) begin
            if (hit_q) begin
              life_d = life_q - 10'd1;
              if (life_q == 10'd1) begin
                state_d     = S_OVER;
                game_over_d = 1'b1;
              end else begin
                state_d = S_HIT;
                cool_d  = CW'(HIT_FRAMES);
              end
            end
          end else begin
            // Cooldown: collisions ignored, including on the frame it expires
            cool_d = cool_q - CW'(1);
            if (cool_q == CW'(1)) state_d = S_PLAY;
          end
          phase_d = PH_WAIT;
        end
        default: phase_d = PH_WAIT;
      endcase
    end else begin
      phase_d = PH_WAIT;
    end
  end

  // State register with asynchronous return to power-on values
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_WAIT;
      lfsr_q      <= LFSR_INIT;
      plane_y_q   <= PLANE_Y_INIT;
      m1_x_q      <= M1_X_INIT;
      m1_y_q      <= M1_Y_INIT;
      m2_x_q      <= M2_X_INIT;
      m2_y_q      <= M2_Y_INIT;
      lava_x_q    <= LAVA_X_INIT;
      lava_y_q    <= LAVA_Y_INIT;
      life_q      <= LIFE_INIT;
      game_over_q <= 1'b0;
      score_q     <= 16'd0;
      hit_q       <= 1'b0;
      cool_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      lfsr_q      <= lfsr_d;
      plane_y_q   <= plane_y_d;
      m1_x_q      <= m1_x_d;
      m1_y_q      <= m1_y_d;
      m2_x_q      <= m2_x_d;
      m2_y_q      <= m2_y_d;
      lava_x_q    <= lava_x_d;
      lava_y_q    <= lava_y_d;
      life_q      <= life_d;
      game_over_q <= game_over_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      cool_q      <= cool_d;
    end
  end

  assign bus.plane_y     = plane_y_q;
  assign bus.mountain1_x = m1_x_q;
  assign bus.mountain1_y = m1_y_q;
  assign bus.mountain2_x = m2_x_q;
  assign bus.mountain2_y = m2_y_q;
  assign bus.lava_x      = lava_x_q;
  assign bus.lava_y      = lava_y_q;
  assign bus.life        = life_q;
  assign bus.game_over   = game_over_q;
  assign bus.score       = score_q;

endmodule

// File: tb/tb_game_engine.sv
// tb/tb_game_engine.sv - directed self-checking bench for game_engine
module tb_game_engine;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  int   frames = 0;

  game_engine_if bus();

  game_engine dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_init(input string tag);
    chk({tag, "_plane_y"}, 32'(bus.plane_y), 232);
    chk({tag, "_m1x"}, 32'(bus.mountain1_x), 640);
    chk({tag, "_m1y"}, 32'(bus.mountain1_y), 380);
    chk({tag, "_m2x"}, 32'(bus.mountain2_x), 960);
    chk({tag, "_m2y"}, 32'(bus.mountain2_y), 340);
    chk({tag, "_lava_x"}, 32'(bus.lava_x), 400);
    chk({tag, "_lava_y"}, 32'(bus.lava_y), 0);
    chk({tag, "_life"}, 32'(bus.life), 3);
    chk({tag, "_game_over"}, 32'(bus.game_over), 0);
    chk({tag, "_score"}, 32'(bus.score), 0);
  endtask

  // One frame: tick for one cycle, then wait out MOVE/CHECK/COMMIT
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      repeat (3) @(negedge clk);
      frames++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    frames = 0;
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    repeat (2) @(negedge clk);
    check_init("reset_asserted");
    resetn = 1'b1;
    @(negedge clk);
    check_init("reset");

    // Ticks in IDLE do nothing
    run(1);
    chk("idle_tick_m1x", 32'(bus.mountain1_x), 640);
    chk("idle_tick_score", 32'(bus.score), 0);

    pulse_start();
    run(10);
    chk("f10_plane_y", 32'(bus.plane_y), 232);
    chk("f10_m1x", 32'(bus.mountain1_x), 620);
    chk("f10_m2x", 32'(bus.mountain2_x), 940);
    chk("f10_lava_y", 32'(bus.lava_y), 30);
    chk("f10_score", 32'(bus.score), 10);
    chk("f10_life", 32'(bus.life), 3);

    // Up: 232/4 = 58 frames to reach the top, then held at 0
    bus.btn_up = 1'b1;
    run(57);
    chk("up57_plane_y", 32'(bus.plane_y), 4);
    run(1);
    chk("up58_plane_y", 32'(bus.plane_y), 0);
    run(12);
    chk("up70_plane_y", 32'(bus.plane_y), 0);
    chk("f80_m1x", 32'(bus.mountain1_x), 480);

    // Both buttons: no movement
    bus.btn_down = 1'b1;
    run(5);
    chk("both_plane_y", 32'(bus.plane_y), 0);
    chk("f85_m2x", 32'(bus.mountain2_x), 790);
    bus.btn_up = 1'b0;

    // Down from 0; lava reaches 477 at frame 159 and wraps at frame 160
    run(74);
    chk("dn74_plane_y", 32'(bus.plane_y), 296);
    chk("f159_lava_y", 32'(bus.lava_y), 477);
    run(1);
    chk("f160_lava_y_wrap", 32'(bus.lava_y), 0);
    chk("f160_lava_x_range", 32'(bus.lava_x >= 10'd200 && bus.lava_x <= 10'd455), 1);
    run(40);
    chk("dn115_plane_y", 32'(bus.plane_y), 460);
    run(1);
    chk("dn116_plane_y_clamp", 32'(bus.plane_y), 463);
    run(4);
    chk("dn120_plane_y_hold", 32'(bus.plane_y), 463);
    chk("f205_m1x", 32'(bus.mountain1_x), 230);
    bus.btn_down = 1'b0;

    // Mountain 1 reaches x=116 at frame 262: first hit, cycle-accurate
    run(56);
    chk("f261_m1x", 32'(bus.mountain1_x), 118);
    chk("f261_life", 32'(bus.life), 3);
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    chk("hit_n0_m1x", 32'(bus.mountain1_x), 118);
    @(negedge clk);
    chk("hit_n1_m1x", 32'(bus.mountain1_x), 116);
    chk("hit_n1_life", 32'(bus.life), 3);
    @(negedge clk);
    chk("hit_n2_life", 32'(bus.life), 3);
    chk("hit_n2_score", 32'(bus.score), 261);
    @(negedge clk);
    chk("hit_n3_life", 32'(bus.life), 2);
    chk("hit_n3_score", 32'(bus.score), 262);
    @(negedge clk);
    frames++;

    // Still overlapping during cooldown: no further loss
    run(23);
    chk("f285_m1x", 32'(bus.mountain1_x), 70);
    chk("cool_life", 32'(bus.life), 2);

    // Mountain 1 wrap: 2 -> 0 -> 640 with fresh y
    run(34);
    chk("f319_m1x", 32'(bus.mountain1_x), 2);
    run(1);
    chk("f320_m1x", 32'(bus.mountain1_x), 0);
    run(1);
    chk("f321_m1x_wrap", 32'(bus.mountain1_x), 640);
    chk("f321_m1y_range", 32'(bus.mountain1_y >= 10'd300 && bus.mountain1_y <= 10'd427), 1);

    // Second hit after cooldown expired: mountain 2 at x=116, frame 422
    run(100);
    chk("f421_m2x", 32'(bus.mountain2_x), 118);
    chk("f421_life", 32'(bus.life), 2);
    run(1);
    chk("f422_life", 32'(bus.life), 1);

    // Third hit: wrapped mountain 1 returns to x=116 at frame 583
    run(160);
    chk("f582_life", 32'(bus.life), 1);
    chk("f582_game_over", 32'(bus.game_over), 0);
    run(1);
    chk("f583_m1x", 32'(bus.mountain1_x), 116);
    chk("f583_life", 32'(bus.life), 0);
    chk("f583_game_over", 32'(bus.game_over), 1);
    chk("f583_score", 32'(bus.score), 583);

    // OVER: ticks ignored, everything frozen
    bus.btn_up = 1'b1;
    run(3);
    bus.btn_up = 1'b0;
    chk("over_m1x", 32'(bus.mountain1_x), 116);
    chk("over_plane_y", 32'(bus.plane_y), 463);
    chk("over_score", 32'(bus.score), 583);
    chk("over_life", 32'(bus.life), 0);

    // Restart from OVER: init values after the next edge
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    frames = 0;
    check_init("restart");
    run(2);
    chk("restart_f2_m1x", 32'(bus.mountain1_x), 636);

    // Start during PLAY is ignored
    bus.start = 1'b1;
    run(1);
    bus.start = 1'b0;
    chk("play_start_m1x", 32'(bus.mountain1_x), 634);
    chk("play_start_score", 32'(bus.score), 3);

    // Asynchronous reset in the middle of CHECK
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_m1x", 32'(bus.mountain1_x), 632);
    resetn = 1'b0;
    #1;
    check_init("mid_check_reset");
    @(negedge clk) resetn = 1'b1;
    run(1);
    chk("post_rst_idle_m1x", 32'(bus.mountain1_x), 640);
    chk("post_rst_idle_score", 32'(bus.score), 0);
    pulse_start();
    run(1);
    chk("post_rst_play_m1x", 32'(bus.mountain1_x), 638);
    chk("post_rst_play_m2x", 32'(bus.mountain2_x), 958);
    chk("post_rst_play_lava_y", 32'(bus.lava_y), 3);
    chk("post_rst_play_score", 32'(bus.score), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
